// File: rtl/divider_unit.sv
// divider_unit -- iterative RV32M divide unit (DIV, DIVU, REM, REMU).
//
// One quotient bit per cycle using a restoring shift/subtract loop on
// operand magnitudes. The signs are applied only when the result is loaded.
//
// Ports:
//   clk      in   core clock, rising edge
//   rst      in   synchronous active-high reset
//   Start    in   request, sampled only while idle
//   DivOp    in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Operand1 in   dividend (rs1)
//   Operand2 in   divisor  (rs2)
//   Flush    in   abort any in-flight operation
//   Busy     out  operation in flight (state != IDLE)
//   Done     out  one-cycle pulse, Result valid
//   Result   out  quotient or remainder, held until the next completion
module divider_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic [1:0]  DivOp,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;

    logic        op_signed;   // DIV / REM
    logic        op_rem;      // REM / REMU
    logic        neg1;        // dividend negative (signed ops only)
    logic        neg2;        // divisor negative (signed ops only)
    logic        special;     // divide-by-zero or signed overflow
    logic [5:0]  cnt;
    logic [31:0] quo;         // dividend bits shift out, quotient bits shift in
    logic [32:0] rem;         // partial remainder
    logic [31:0] dvsr;        // divisor magnitude

    // Decode of the incoming request.
    logic        in_signed;
    logic        in_neg1, in_neg2;
    logic [31:0] in_mag1, in_mag2;
    logic        in_div0, in_ovf;

    assign in_signed = ~DivOp[0];
    assign in_neg1   = in_signed & Operand1[31];
    assign in_neg2   = in_signed & Operand2[31];
    assign in_mag1   = in_neg1 ? (32'd0 - Operand1) : Operand1;
    assign in_mag2   = in_neg2 ? (32'd0 - Operand2) : Operand2;
    assign in_div0   = (Operand2 == 32'd0);
    assign in_ovf    = in_signed & (Operand1 == 32'h8000_0000) & (Operand2 == 32'hFFFF_FFFF);

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The extra top bit of the difference is the borrow.
    logic [33:0] trial;
    logic        fits;

    assign trial = {rem, quo[31]} - {2'b00, dvsr};
    assign fits  = ~trial[33];

    // Sign fix-up. Special cases already hold their final raw values.
    logic [31:0] q_fix, r_fix, fix_val;

    assign q_fix   = (op_signed & (neg1 ^ neg2) & ~special) ? (32'd0 - quo) : quo;
    assign r_fix   = (op_signed & neg1 & ~special) ? (32'd0 - rem[31:0]) : rem[31:0];
    assign fix_val = op_rem ? r_fix : q_fix;

    assign Busy = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start) state_next = (in_div0 | in_ovf) ? FIX : CALC;
            CALC: if (cnt == 6'd31) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (Flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_signed <= 1'b0;
            op_rem    <= 1'b0;
            neg1      <= 1'b0;
            neg2      <= 1'b0;
            special   <= 1'b0;
            cnt       <= 6'd0;
            quo       <= 32'd0;
            rem       <= 33'd0;
            dvsr      <= 32'd0;
            Done      <= 1'b0;
            Result    <= 32'd0;
        end else begin
            state <= state_next;
            Done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        op_signed <= in_signed;
                        op_rem    <= DivOp[1];
                        neg1      <= in_neg1;
                        neg2      <= in_neg2;
                        special   <= in_div0 | in_ovf;
                        cnt       <= 6'd0;
                        dvsr      <= in_mag2;
                        if (in_div0) begin
                            // quotient all ones, remainder is the raw dividend
                            quo <= 32'hFFFF_FFFF;
                            rem <= {1'b0, Operand1};
                        end else if (in_ovf) begin
                            quo <= 32'h8000_0000;
                            rem <= 33'd0;
                        end else begin
                            quo <= in_mag1;
                            rem <= 33'd0;
                        end
                    end
                end
                CALC: begin
                    if (!Flush) begin
                        rem <= fits ? trial[32:0] : {rem[31:0], quo[31]};
                        quo <= {quo[30:0], fits};
                        cnt <= cnt + 6'd1;
                    end
                end
                FIX: begin
                    if (!Flush) begin
                        Result <= fix_val;
                        Done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
module tb_divider_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [1:0]  DivOp;
    logic [31:0] Operand1, Operand2;
    logic        Flush;
    logic        Busy, Done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    divider_unit dut (
        .clk(clk), .rst(rst), .Start(Start), .DivOp(DivOp),
        .Operand1(Operand1), .Operand2(Operand2), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for Done. lat counts edges from the accepting
    // edge (inclusive) to the edge after which Done is high. busy_pre is
    // Busy in the cycle just before Done.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_pre);
        logic prev;
        Start = 1'b1; DivOp = op; Operand1 = a; Operand2 = b;
        tick();
        Start = 1'b0; Operand1 = 32'hDEAD_BEEF; Operand2 = 32'h1234_5678; DivOp = 2'b00;
        lat = 1;
        prev = Busy;
        busy_pre = 1'b0;
        while (!Done && lat < 100) begin
            prev = Busy;
            tick();
            lat++;
        end
        busy_pre = prev;
        res = Result;
        if (!Done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout op=%0d a=%h b=%h: no Done within 100 cycles", op, a, b);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            OP_DIV:  return 32'(sa / sb);
            OP_DIVU: return a / b;
            OP_REM:  return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Flush = 1'b0; DivOp = 2'b00; Operand1 = 0; Operand2 = 0;
        tick(); tick();
        checks++;
        if ({Busy, Done, Result} !== 34'd0) begin
            errors++;
            $display("FAIL reset busy=%b done=%b result=%h, want 0/0/00000000", Busy, Done, Result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_signed_timing();
        logic [31:0] r; int lat; logic bp;
        logic [1:0] ops [2] = '{OP_DIV, OP_REM};
        logic [31:0] exp [2] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF};
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], 32'hFFFF_FFF9, 32'd2, r, lat, bp);
            checks++;
            if (r !== exp[i]) begin
                errors++; $display("FAIL neg7_by_2 op=%0d result=%h want %h", ops[i], r, exp[i]);
            end
            checks++;
            if (lat !== 34) begin
                errors++; $display("FAIL normal_latency got %0d want 34", lat);
            end
            checks++;
            if (bp !== 1'b1 || Busy !== 1'b0) begin
                errors++; $display("FAIL busy_at_done pre=%b at_done=%b want 1/0", bp, Busy);
            end
            tick();
            checks++;
            if (Done !== 1'b0) begin
                errors++; $display("FAIL done_pulse_width done=%b want 0", Done);
            end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] r; int lat; logic bp;
        logic [1:0]  op [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] a  [4] = '{32'hFFFF_FFFF, 32'd100, 32'd7, 32'd7};
        logic [31:0] b  [4] = '{32'd3, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] e  [4] = '{32'h5555_5555, 32'd2, 32'hFFFF_FFFD, 32'd1};
        for (int i = 0; i < 4; i++) begin
            do_op(op[i], a[i], b[i], r, lat, bp);
            checks++;
            if (r !== e[i]) begin
                errors++; $display("FAIL vector%0d result=%h want %h", i, r, e[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat; logic bp;
        logic [1:0]  op [5] = '{OP_DIVU, OP_REMU, OP_DIV, OP_DIV, OP_REM};
        logic [31:0] a  [5] = '{32'd5, 32'd5, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e  [5] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 5; i++) begin
            do_op(op[i], a[i], b[i], r, lat, bp);
            checks++;
            if (r !== e[i]) begin
                errors++; $display("FAIL special%0d result=%h want %h", i, r, e[i]);
            end
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL special%0d_latency got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prior; int seen;
        prior = Result;
        Start = 1'b1; DivOp = OP_DIVU; Operand1 = 32'd1000; Operand2 = 32'd3;
        tick();
        Start = 1'b0;
        repeat (10) tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++; $display("FAIL flush_state busy=%b done=%b want 0/0", Busy, Done);
        end
        seen = 0;
        repeat (40) begin
            if (Done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || Result !== prior) begin
            errors++; $display("FAIL flush_quiet dones=%0d result=%h want 0/%h", seen, Result, prior);
        end
    endtask

    task automatic test_start_flush_idle();
        Start = 1'b1; Flush = 1'b1; DivOp = OP_DIVU; Operand1 = 32'd9; Operand2 = 32'd0;
        tick();
        Start = 1'b0; Flush = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++; $display("FAIL start_flush_idle busy=%b want 0", Busy);
        end
        tick(); tick();
        checks++;
        if (Done !== 1'b0) begin
            errors++; $display("FAIL start_flush_idle_done done=%b want 0", Done);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, seen;
        Start = 1'b1; DivOp = OP_DIVU; Operand1 = 32'd50; Operand2 = 32'd5;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Start = 1'b1; DivOp = OP_REMU; Operand1 = 32'd77; Operand2 = 32'd0;
        tick();
        Start = 1'b0;
        lat = 6;
        while (!Done && lat < 100) begin tick(); lat++; end
        checks++;
        if (Done !== 1'b1 || Result !== 32'd10 || lat !== 34) begin
            errors++; $display("FAIL start_busy_ignored done=%b result=%h lat=%0d want 1/0000000a/34", Done, Result, lat);
        end
        seen = 0;
        tick();
        repeat (40) begin if (Done || Busy) seen++; tick(); end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL start_busy_no_second activity=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat; logic bp;
        do_op(OP_DIVU, 32'd200, 32'd10, r, lat, bp);
        // Done is high now; issue the next op on this cycle.
        do_op(OP_REM, 32'hFFFF_FFEC, 32'd6, r, lat, bp);
        checks++;
        if (r !== 32'hFFFF_FFFE || lat !== 34) begin
            errors++; $display("FAIL back_to_back result=%h lat=%0d want fffffffe/34", r, lat);
        end
    endtask

    task automatic test_reset_mid();
        Start = 1'b1; DivOp = OP_DIV; Operand1 = 32'd12345; Operand2 = 32'd7;
        tick();
        Start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({Busy, Done, Result} !== 34'd0) begin
            errors++; $display("FAIL reset_mid busy=%b done=%b result=%h want 0/0/0", Busy, Done, Result);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, e; int lat; logic bp;
        logic [1:0] op;
        for (int i = 0; i < 1600; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = $urandom_range(0, 3);
                1: b = 32'hFFFF_FFFF - $urandom_range(0, 2);
                2: a = 32'h8000_0000;
                3: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            e = model(op, a, b);
            do_op(op, a, b, r, lat, bp);
            checks++;
            if (r !== e) begin
                errors++; $display("FAIL random op=%0d a=%h b=%h result=%h want %h", op, a, b, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_timing();
        test_vectors();
        test_special();
        test_flush();
        test_start_flush_idle();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
